// File: rtl/frame_buffer_reader.sv
// Host-side frame buffer reader: waits for the writer's toggle, streams every buffer
// word out MSB byte first on a valid/ready byte link, then toggles handshakePC back.
module frame_buffer_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              handshakeFPGA,
    output logic              handshakePC,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [31:0]       frames_read
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NB - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shifted;
    logic [CNT_W-1:0]  byte_cnt;
    logic              accept;
    logic              last_byte;

    assign accept    = tx_valid & tx_ready;
    assign last_byte = (byte_cnt == LAST_CNT);
    assign shifted   = shift_reg << 8;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:  if (handshakeFPGA != handshakePC) state_next = S_FETCH;
            S_FETCH: begin
                rd_en      = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT:  state_next = S_SEND;
            S_SEND:  if (accept && last_byte)
                         state_next = (rd_addr == LAST_ADDR) ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The handshake is only looked at in IDLE, so writer toggles mid-frame wait their turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            handshakePC <= 1'b0;
            rd_addr     <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            frames_read <= '0;
            byte_cnt    <= '0;
            shift_reg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (handshakeFPGA != handshakePC) rd_addr <= '0;
                end
                S_WAIT: begin
                    shift_reg <= rd_data;
                    tx_data   <= rd_data[DATA_W-1 -: 8];
                    tx_valid  <= 1'b1;
                    byte_cnt  <= '0;
                end
                S_SEND: begin
                    if (accept) begin
                        if (!last_byte) begin
                            shift_reg <= shifted;
                            tx_data   <= shifted[DATA_W-1 -: 8];
                            byte_cnt  <= byte_cnt + 1'b1;
                        end else begin
                            tx_valid <= 1'b0;
                            if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    handshakePC <= ~handshakePC;
                    frames_read <= frames_read + 32'd1;
                    rd_addr     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
